ssd_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver replacing the fixed 4-digit scan logic in the board top level. Drives NUM_DIGITS common-anode digits from a packed hex bus. Adds per-digit decimal points, per-digit enables, 16-level PWM brightness and optional leading-zero blanking. Sits between game/status logic and the An*/Ca..Cg/Dp board pins; all outputs are registered.

---
 rtl/ssd_scan_driver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver with 16-level PWM brightness.
// Optional leading-zero blanking is built when SSD_LEADING_ZERO_BLANK_EN is defined.
module ssd_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              cathodes,
  output logic [2:0]              scan_idx,
  output logic                    frame_tick
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] presc;
  logic                     primed;
  logic                     loaded;
  logic [3:0]               snap_nib;
  logic                     snap_dp;
  logic                     snap_en;
  logic                     snap_blank;

  logic                     load;
  logic [2:0]               next_idx;
  logic [2:0]               load_idx;
  logic [3:0]               sel_nib;
  logic                     sel_dp;
  logic                     sel_en;
  logic                     sel_blank;
  logic [NUM_DIGITS-1:0]    blank_vec;
  logic [NUM_DIGITS-1:0]    anode_nxt;
  logic [7:0]               cathode_nxt;
  logic [3:0]               phase;
  logic                     lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  assign phase    = presc[SCAN_DIV_BITS-1 -: 4];
  assign next_idx = (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
  // The first clock after reset captures digit 0 without waiting for a prescaler wrap.
  assign load     = !primed || (presc == '1);
  assign load_idx = primed ? next_idx : 3'd0;
  assign lit      = snap_en && !snap_blank && (phase <= brightness);

  always_comb begin
    blank_vec = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        upper_zero   = upper_zero && (digits[4*k +: 4] == 4'h0);
        blank_vec[k] = upper_zero;
      end
    end
`endif
  end

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_en    = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (load_idx == 3'(k)) begin
        sel_nib   = digits[4*k +: 4];
        sel_dp    = dp_en[k];
        sel_en    = digit_en[k];
        sel_blank = blank_vec[k];
      end
    end
  end

  always_comb begin
    anode_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      anode_nxt[k] = !(lit && (scan_idx == 3'(k)));
    end
    cathode_nxt = lit ? {hex_to_seg(snap_nib), ~snap_dp} : 8'hFF;
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      presc      <= '0;
      scan_idx   <= 3'd0;
      primed     <= 1'b0;
      loaded     <= 1'b0;
      snap_nib   <= 4'h0;
      snap_dp    <= 1'b0;
      snap_en    <= 1'b0;
      snap_blank <= 1'b0;
      anodes     <= '1;
      cathodes   <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      presc      <= presc + 1'b1;
      anodes     <= anode_nxt;
      cathodes   <= cathode_nxt;
      frame_tick <= loaded && (scan_idx == 3'd0);
      loaded     <= load;
      if (load) begin
        primed     <= 1'b1;
        scan_idx   <= load_idx;
        snap_nib   <= sel_nib;
        snap_dp    <= sel_dp;
        snap_en    <= sel_en;
        snap_blank <= sel_blank;
      end
    end
  end
endmodule
